// File: rtl/cam_req_arb_if.sv
// Client/CAM bundle for cam_req_arb: two write clients, two lookup clients
// and the CAM write/compare port. slave = arbiter view, master = environment.
interface cam_req_arb_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 9
);
  logic                  wr_valid0, wr_valid1;
  logic                  wr_ready0, wr_ready1;
  logic                  wr_del0, wr_del1;
  logic [ADDR_WIDTH-1:0] wr_addr0, wr_addr1;
  logic [DATA_WIDTH-1:0] wr_data0, wr_data1;

  logic                  lk_valid0, lk_valid1;
  logic                  lk_ready0, lk_ready1;
  logic [DATA_WIDTH-1:0] lk_data0, lk_data1;

  logic                  rsp_valid0, rsp_valid1;
  logic                  rsp_match0, rsp_match1;
  logic [ADDR_WIDTH-1:0] rsp_addr0, rsp_addr1;

  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_delete, write_enable, write_busy;
  logic [DATA_WIDTH-1:0] compare_data;
  logic                  match;
  logic [ADDR_WIDTH-1:0] match_addr;

  modport slave (
    input  wr_valid0, wr_valid1, wr_del0, wr_del1, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  lk_valid0, lk_valid1, lk_data0, lk_data1,
    input  write_busy, match, match_addr,
    output wr_ready0, wr_ready1, lk_ready0, lk_ready1,
    output rsp_valid0, rsp_valid1, rsp_match0, rsp_match1, rsp_addr0, rsp_addr1,
    output write_addr, write_data, write_delete, write_enable, compare_data
  );

  modport master (
    output wr_valid0, wr_valid1, wr_del0, wr_del1, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output lk_valid0, lk_valid1, lk_data0, lk_data1,
    output write_busy, match, match_addr,
    input  wr_ready0, wr_ready1, lk_ready0, lk_ready1,
    input  rsp_valid0, rsp_valid1, rsp_match0, rsp_match1, rsp_addr0, rsp_addr1,
    input  write_addr, write_data, write_delete, write_enable, compare_data
  );
endinterface

// File: rtl/cam_req_arb.sv
// Two-client round-robin arbiter in front of a CAM: serialises writes through
// an IDLE/ISSUE/WAIT FSM and pipelines lookups, routing results back by tag.
module cam_req_arb #(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDR_WIDTH    = 9,
  parameter int MATCH_LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  cam_req_arb_if.slave bus
);
  // Stage 1 lines up with compare_data; the tail lines up with match.
  localparam int STAGES = MATCH_LATENCY + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
  state_e state_q, state_d;

  logic [1:0]                 wr_vld, wr_del, lk_vld;
  logic [1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [1:0][DATA_WIDTH-1:0] wr_data, lk_data;

  assign wr_vld  = {bus.wr_valid1, bus.wr_valid0};
  assign wr_del  = {bus.wr_del1, bus.wr_del0};
  assign wr_addr = {bus.wr_addr1, bus.wr_addr0};
  assign wr_data = {bus.wr_data1, bus.wr_data0};
  assign lk_vld  = {bus.lk_valid1, bus.lk_valid0};
  assign lk_data = {bus.lk_data1, bus.lk_data0};

  // On a tie the client not granted last wins; otherwise the sole requester.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

  logic wr_last_q, lk_last_q;
  logic wr_sel, lk_sel, wr_gnt, lk_acc;

  assign wr_sel = rr_pick(wr_vld, wr_last_q);
  assign lk_sel = rr_pick(lk_vld, lk_last_q);

  always_comb begin
    state_d = state_q;
    wr_gnt  = 1'b0;
    lk_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.write_busy) begin
          wr_gnt = |wr_vld;
          lk_acc = |lk_vld;
          if (wr_gnt) state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (!bus.write_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshakes are combinational, so keep them quiet while reset is held.
    if (!rst) begin
      state_d = IDLE;
      wr_gnt  = 1'b0;
      lk_acc  = 1'b0;
    end
  end

  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, cmp_q;
  logic                  wdel_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wdel_q    <= 1'b0;
      cmp_q     <= '0;
      wr_last_q <= 1'b1;
      lk_last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (wr_gnt) begin
        waddr_q   <= wr_addr[wr_sel];
        wdata_q   <= wr_data[wr_sel];
        wdel_q    <= wr_del[wr_sel];
        wr_last_q <= wr_sel;
      end
      if (lk_acc) begin
        cmp_q     <= lk_data[lk_sel];
        lk_last_q <= lk_sel;
      end
    end
  end

  logic [STAGES:1] vld_pipe, tag_pipe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], lk_acc};
      tag_pipe <= {tag_pipe[STAGES-1:1], lk_sel};
    end
  end

  logic [1:0]                 rsp_hit, rsp_match_q;
  logic [1:0][ADDR_WIDTH-1:0] rsp_addr_q;

  always_comb begin
    rsp_hit = '0;
    if (rst && vld_pipe[STAGES]) rsp_hit[tag_pipe[STAGES]] = 1'b1;
  end

  // The non-addressed client keeps showing its previous result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_match_q <= '0;
      rsp_addr_q  <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (rsp_hit[c]) begin
          rsp_match_q[c] <= bus.match;
          rsp_addr_q[c]  <= bus.match_addr;
        end
      end
    end
  end

  assign bus.wr_ready0    = wr_gnt & ~wr_sel;
  assign bus.wr_ready1    = wr_gnt & wr_sel;
  assign bus.lk_ready0    = lk_acc & ~lk_sel;
  assign bus.lk_ready1    = lk_acc & lk_sel;
  assign bus.write_enable = rst & (state_q == ISSUE);
  assign bus.write_addr   = waddr_q;
  assign bus.write_data   = wdata_q;
  assign bus.write_delete = wdel_q;
  assign bus.compare_data = cmp_q;

  assign bus.rsp_valid0 = rsp_hit[0];
  assign bus.rsp_valid1 = rsp_hit[1];
  assign bus.rsp_match0 = rsp_hit[0] ? bus.match : rsp_match_q[0];
  assign bus.rsp_match1 = rsp_hit[1] ? bus.match : rsp_match_q[1];
  assign bus.rsp_addr0  = rsp_hit[0] ? bus.match_addr : rsp_addr_q[0];
  assign bus.rsp_addr1  = rsp_hit[1] ? bus.match_addr : rsp_addr_q[1];
endmodule

// File: tb/tb_cam_req_arb.sv
// Bench for cam_req_arb: directed scenarios plus a randomized run against a
// cycle-budget reference model with a small behavioural CAM.
module tb_cam_req_arb;
  localparam int DW = 24;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cam_req_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  cam_req_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATCH_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic        cl;
    logic        m;
    logic [AW-1:0] a;
  } rsp_t;

  logic [DW-1:0] kmem [16];
  logic          kval [16];

  function automatic logic [84:0] outs();
    return {bus.wr_ready0, bus.wr_ready1, bus.lk_ready0, bus.lk_ready1,
            bus.rsp_valid0, bus.rsp_valid1, bus.rsp_match0, bus.rsp_match1,
            bus.rsp_addr0, bus.rsp_addr1, bus.write_addr, bus.write_data,
            bus.write_delete, bus.write_enable, bus.compare_data};
  endfunction

  task automatic idle_inputs();
    bus.wr_valid0 = 0; bus.wr_valid1 = 0; bus.wr_del0 = 0; bus.wr_del1 = 0;
    bus.wr_addr0 = '0; bus.wr_addr1 = '0; bus.wr_data0 = '0; bus.wr_data1 = '0;
    bus.lk_valid0 = 0; bus.lk_valid1 = 0; bus.lk_data0 = '0; bus.lk_data1 = '0;
    bus.write_busy = 0; bus.match = 0; bus.match_addr = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 0;
    bus.wr_valid0 = 1; bus.wr_valid1 = 1; bus.lk_valid0 = 1; bus.lk_valid1 = 1;
    bus.wr_data0 = 24'h0F0F0F; bus.lk_data1 = 24'h777777;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs() !== 85'd0) begin
      failures++; $display("FAIL reset_outs got %h exp 0", outs());
    end
    @(posedge clk); #1;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (outs() !== 85'd0) begin
      failures++; $display("FAIL post_reset_outs got %h exp 0", outs());
    end
  endtask

  task automatic test_write_rr();
    logic [1:0] exp_rdy;
    do_reset();
    bus.wr_addr0 = 9'h005; bus.wr_data0 = 24'h123456;
    bus.wr_addr1 = 9'h1A0; bus.wr_data1 = 24'hABCDEF;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bus.wr_valid0  = (k == 0);
      bus.wr_valid1  = (k <= 5);
      bus.write_busy = (k == 2 || k == 3 || k == 7);
      @(negedge clk);
      exp_rdy = {k == 5, k == 0};
      checks++;
      if ({bus.wr_ready1, bus.wr_ready0} !== exp_rdy) begin
        failures++; $display("FAIL wr_rr_ready k=%0d got %b exp %b", k, {bus.wr_ready1, bus.wr_ready0}, exp_rdy);
      end
      checks++;
      if (bus.write_enable !== (k == 1 || k == 6)) begin
        failures++; $display("FAIL wr_rr_we k=%0d got %b exp %b", k, bus.write_enable, (k == 1 || k == 6));
      end
      if (k >= 1) begin
        checks++;
        if ({bus.write_addr, bus.write_data} !== ((k <= 5) ? {9'h005, 24'h123456} : {9'h1A0, 24'hABCDEF})) begin
          failures++; $display("FAIL wr_rr_latch k=%0d got %h/%h", k, bus.write_addr, bus.write_data);
        end
      end
    end
  endtask

  task automatic test_lookup_single();
    do_reset();
    bus.lk_data0 = 24'h123456;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bus.lk_valid0  = (k == 0);
      bus.match      = (k == 2);
      bus.match_addr = (k == 2) ? 9'h005 : 9'h000;
      @(negedge clk);
      checks++;
      if ({bus.lk_ready1, bus.lk_ready0} !== {1'b0, k == 0}) begin
        failures++; $display("FAIL lk1_ready k=%0d got %b", k, {bus.lk_ready1, bus.lk_ready0});
      end
      checks++;
      if ({bus.rsp_valid1, bus.rsp_valid0} !== {1'b0, k == 2}) begin
        failures++; $display("FAIL lk1_rsp_valid k=%0d got %b exp %b", k, {bus.rsp_valid1, bus.rsp_valid0}, {1'b0, k == 2});
      end
      if (k == 1) begin
        checks++;
        if (bus.compare_data !== 24'h123456) begin
          failures++; $display("FAIL lk1_cmp got %h exp 123456", bus.compare_data);
        end
      end
      if (k >= 2) begin
        checks++;
        if ({bus.rsp_match0, bus.rsp_addr0, bus.rsp_match1} !== {1'b1, 9'h005, 1'b0}) begin
          failures++; $display("FAIL lk1_rsp_data k=%0d got %b/%h/%b exp 1/005/0", k, bus.rsp_match0, bus.rsp_addr0, bus.rsp_match1);
        end
      end
    end
  endtask

  task automatic test_lookup_alternate();
    logic [DW-1:0] acc_key [8];
    logic          acc_cl  [8];
    logic [1:0]    exp_v;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      bus.lk_valid0  = (k < 6);
      bus.lk_valid1  = (k < 6);
      bus.lk_data0   = DW'(24'h100000 + k);
      bus.lk_data1   = DW'(24'h200000 + k);
      bus.match      = (k % 3 == 0);
      bus.match_addr = AW'(k * 7);
      @(negedge clk);
      if (k < 6) begin
        acc_cl[k]  = (k % 2 == 1);
        acc_key[k] = acc_cl[k] ? bus.lk_data1 : bus.lk_data0;
      end
      checks++;
      if ({bus.lk_ready1, bus.lk_ready0} !== ((k < 6) ? ((k % 2 == 1) ? 2'b10 : 2'b01) : 2'b00)) begin
        failures++; $display("FAIL alt_ready k=%0d got %b", k, {bus.lk_ready1, bus.lk_ready0});
      end
      if (k >= 1 && k <= 6) begin
        checks++;
        if (bus.compare_data !== acc_key[k-1]) begin
          failures++; $display("FAIL alt_cmp k=%0d got %h exp %h", k, bus.compare_data, acc_key[k-1]);
        end
      end
      exp_v = 2'b00;
      if (k >= 2 && k <= 7) exp_v[acc_cl[k-2]] = 1'b1;
      checks++;
      if ({bus.rsp_valid1, bus.rsp_valid0} !== exp_v) begin
        failures++; $display("FAIL alt_rsp_valid k=%0d got %b exp %b", k, {bus.rsp_valid1, bus.rsp_valid0}, exp_v);
      end
      if (exp_v != 2'b00) begin
        checks++;
        if ((exp_v[1] ? {bus.rsp_match1, bus.rsp_addr1} : {bus.rsp_match0, bus.rsp_addr0}) !== {k % 3 == 0, AW'(k * 7)}) begin
          failures++; $display("FAIL alt_rsp_data k=%0d got %b/%h/%b/%h", k, bus.rsp_match0, bus.rsp_addr0, bus.rsp_match1, bus.rsp_addr1);
        end
      end
    end
  endtask

  task automatic test_lookup_blocked();
    do_reset();
    bus.wr_addr0 = 9'h003; bus.wr_data0 = 24'h0000AA;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bus.wr_valid0  = (k == 0);
      bus.lk_valid1  = (k <= 5);
      bus.lk_data1   = DW'(24'h300000 + k);
      bus.write_busy = (k == 2 || k == 3);
      @(negedge clk);
      checks++;
      if ({bus.wr_ready0, bus.lk_ready1, bus.lk_ready0} !== {k == 0, k == 0 || k == 5, 1'b0}) begin
        failures++; $display("FAIL blk_ready k=%0d got %b", k, {bus.wr_ready0, bus.lk_ready1, bus.lk_ready0});
      end
      checks++;
      if ({bus.write_enable, bus.rsp_valid1, bus.rsp_valid0} !== {k == 1, k == 2 || k == 7, 1'b0}) begin
        failures++; $display("FAIL blk_we_rsp k=%0d got %b", k, {bus.write_enable, bus.rsp_valid1, bus.rsp_valid0});
      end
      if (k == 1 || k == 6) begin
        checks++;
        if (bus.compare_data !== ((k == 1) ? 24'h300000 : 24'h300005)) begin
          failures++; $display("FAIL blk_cmp k=%0d got %h", k, bus.compare_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    bus.wr_addr0 = 9'h011; bus.wr_data0 = 24'h5A5A5A; bus.lk_data0 = 24'h5A5A5A;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      bus.wr_valid0 = (k == 0 || k == 6);
      bus.wr_valid1 = (k == 6);
      bus.lk_valid0 = (k == 0 || k == 6);
      bus.lk_valid1 = (k == 6);
      bus.match     = 1'b1;
      rst           = !(k == 1);
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if ({bus.wr_ready0, bus.lk_ready0} !== 2'b11) begin
          failures++; $display("FAIL rmw_pre_grant got %b exp 11", {bus.wr_ready0, bus.lk_ready0});
        end
      end else if (k == 2) begin
        checks++;
        if (outs() !== 85'd0) begin
          failures++; $display("FAIL rmw_outs_zero got %h exp 0", outs());
        end
      end else if (k == 6) begin
        checks++;
        if ({bus.wr_ready1, bus.wr_ready0, bus.lk_ready1, bus.lk_ready0} !== 4'b0101) begin
          failures++; $display("FAIL rmw_tie got %b exp 0101", {bus.wr_ready1, bus.wr_ready0, bus.lk_ready1, bus.lk_ready0});
        end
      end else begin
        checks++;
        if ({bus.write_enable, bus.rsp_valid1, bus.rsp_valid0} !== 3'b000) begin
          failures++; $display("FAIL rmw_quiet k=%0d got %b exp 000", k, {bus.write_enable, bus.rsp_valid1, bus.rsp_valid0});
        end
      end
    end
  endtask

  task automatic test_random();
    rsp_t          q[$];
    rsp_t          r;
    int            g_cyc = -100, blen = 0, free_at = 0;
    logic          wl = 1'b1, ll = 1'b1, wsel = 1'b0, lsel = 1'b0, act;
    logic [AW-1:0] e_waddr = '0, na = '0, ha;
    logic [DW-1:0] e_wdata = '0, e_cmp = '0, key;
    logic          e_wdel = 1'b0, nm = 1'b0, h, e_we;
    logic [1:0]    wv, lv, e_wr, e_lk, e_rv, held_m = '0;
    logic [AW-1:0] held_a [2];
    held_a[0] = '0; held_a[1] = '0;
    for (int i = 0; i < 16; i++) begin kval[i] = 1'b0; kmem[i] = '0; end
    do_reset();
    for (int c = 0; c < 420; c++) begin
      @(posedge clk); #1;
      act = (c < 400);
      bus.wr_valid0  = act && ($urandom_range(0, 99) < 45);
      bus.wr_valid1  = act && ($urandom_range(0, 99) < 45);
      bus.lk_valid0  = act && ($urandom_range(0, 99) < 55);
      bus.lk_valid1  = act && ($urandom_range(0, 99) < 55);
      bus.wr_del0    = ($urandom_range(0, 3) == 0);
      bus.wr_del1    = ($urandom_range(0, 3) == 0);
      bus.wr_addr0   = AW'($urandom_range(0, 15));
      bus.wr_addr1   = AW'($urandom_range(0, 15));
      bus.wr_data0   = DW'(24'h100000 + $urandom_range(0, 7));
      bus.wr_data1   = DW'(24'h100000 + $urandom_range(0, 7));
      bus.lk_data0   = DW'(24'h100000 + $urandom_range(0, 7));
      bus.lk_data1   = DW'(24'h100000 + $urandom_range(0, 7));
      bus.write_busy = (c >= g_cyc + 2) && (c <= g_cyc + 1 + blen);
      bus.match      = nm;
      bus.match_addr = na;
      @(negedge clk);

      e_we = (c == g_cyc + 1);
      checks++;
      if (bus.write_enable !== e_we) begin
        failures++; $display("FAIL rnd_we c=%0d got %b exp %b", c, bus.write_enable, e_we);
      end
      checks++;
      if ({bus.write_addr, bus.write_data, bus.write_delete} !== {e_waddr, e_wdata, e_wdel}) begin
        failures++; $display("FAIL rnd_wfields c=%0d got %h/%h/%b exp %h/%h/%b", c, bus.write_addr, bus.write_data, bus.write_delete, e_waddr, e_wdata, e_wdel);
      end

      wv = {bus.wr_valid1, bus.wr_valid0};
      lv = {bus.lk_valid1, bus.lk_valid0};
      e_wr = 2'b00;
      e_lk = 2'b00;
      if (c >= free_at && wv != 2'b00) begin
        wsel = (wv == 2'b11) ? ~wl : wv[1];
        e_wr[wsel] = 1'b1;
      end
      if (c >= free_at && lv != 2'b00) begin
        lsel = (lv == 2'b11) ? ~ll : lv[1];
        e_lk[lsel] = 1'b1;
      end
      checks++;
      if ({bus.wr_ready1, bus.wr_ready0, bus.lk_ready1, bus.lk_ready0} !== {e_wr, e_lk}) begin
        failures++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, {bus.wr_ready1, bus.wr_ready0, bus.lk_ready1, bus.lk_ready0}, {e_wr, e_lk});
      end
      checks++;
      if (bus.compare_data !== e_cmp) begin
        failures++; $display("FAIL rnd_cmp c=%0d got %h exp %h", c, bus.compare_data, e_cmp);
      end

      e_rv = 2'b00;
      if (q.size() > 0 && q[0].due == c) begin
        r = q.pop_front();
        e_rv[r.cl]   = 1'b1;
        held_m[r.cl] = r.m;
        held_a[r.cl] = r.a;
      end
      checks++;
      if ({bus.rsp_valid1, bus.rsp_valid0} !== e_rv) begin
        failures++; $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, {bus.rsp_valid1, bus.rsp_valid0}, e_rv);
      end
      checks++;
      if ({bus.rsp_match1, bus.rsp_match0, bus.rsp_addr1, bus.rsp_addr0} !== {held_m, held_a[1], held_a[0]}) begin
        failures++; $display("FAIL rnd_rsp_data c=%0d got %b%b/%h/%h exp %b/%h/%h", c, bus.rsp_match1, bus.rsp_match0, bus.rsp_addr1, bus.rsp_addr0, held_m, held_a[1], held_a[0]);
      end

      // Reference model bookkeeping for the cycle just checked.
      if (e_wr != 2'b00) begin
        e_waddr = wsel ? bus.wr_addr1 : bus.wr_addr0;
        e_wdata = wsel ? bus.wr_data1 : bus.wr_data0;
        e_wdel  = wsel ? bus.wr_del1  : bus.wr_del0;
        g_cyc   = c;
        blen    = $urandom_range(1, 3);
        free_at = c + 3 + blen;
        wl      = wsel;
      end
      if (e_lk != 2'b00) begin
        key = lsel ? bus.lk_data1 : bus.lk_data0;
        h = 1'b0; ha = '0;
        for (int i = 15; i >= 0; i--) if (kval[i] && kmem[i] == key) begin h = 1'b1; ha = AW'(i); end
        q.push_back('{c + 2, lsel, h, ha});
        e_cmp = key;
        ll    = lsel;
      end

      // Behavioural CAM: compare result one cycle later, write takes effect after.
      nm = 1'b0; na = '0;
      for (int i = 15; i >= 0; i--) if (kval[i] && kmem[i] == bus.compare_data) begin nm = 1'b1; na = AW'(i); end
      if (bus.write_enable === 1'b1) begin
        kval[bus.write_addr[3:0]] = !bus.write_delete;
        kmem[bus.write_addr[3:0]] = bus.write_data;
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++; $display("FAIL rnd_drain got %0d pending exp 0", q.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_rr();
    test_lookup_single();
    test_lookup_alternate();
    test_lookup_blocked();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule

// File: doc/cam_req_arb.md
CAM_REQ_ARB -- requirements
Module: cam_req_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, CAM key width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, CAM entry address width.
REQ-003 SHALL have parameter MATCH_LATENCY, default 1, cycles from compare_data driven to match/match_addr valid (range 1..4).
REQ-004 SHALL use one clock; reset is synchronous and active-low; ports named clk and rst.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous active-low reset (0 = reset).
REQ-007 wr_valid0/wr_valid1  in  1  client write request pending.
REQ-008 wr_ready0/wr_ready1  out  1  one-cycle accept pulse; a request transfers when valid and ready are both 1.
REQ-009 wr_del0/wr_del1  in  1  1 = delete entry, 0 = write entry.
REQ-010 wr_addr0/wr_addr1  in  ADDR_WIDTH  target entry.
REQ-011 wr_data0/wr_data1  in  DATA_WIDTH  key to store.
REQ-012 lk_valid0/lk_valid1  in  1  client lookup request pending.
REQ-013 lk_ready0/lk_ready1  out  1  lookup accept pulse.
REQ-014 lk_data0/lk_data1  in  DATA_WIDTH  lookup key.
REQ-015 rsp_valid0/rsp_valid1  out  1  one-cycle lookup result strobe.
REQ-016 rsp_match0/rsp_match1  out  1  result hit flag.
REQ-017 rsp_addr0/rsp_addr1  out  ADDR_WIDTH  result entry address.
REQ-018 write_addr, write_data, write_delete, write_enable  out  ADDR_WIDTH/DATA_WIDTH/1/1  CAM write port.
REQ-019 write_busy  in  1  CAM write in progress; rises the cycle after write_enable.
REQ-020 compare_data  out  DATA_WIDTH  CAM compare key (registered).
REQ-021 match, match_addr  in  1/ADDR_WIDTH  CAM compare result.

Function
REQ-022 Write FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-023 IDLE: if any wr_valid and write_busy=0, grant one client, pulse its wr_ready, latch del/addr/data into write_* registers, go ISSUE; otherwise stay.
REQ-024 ISSUE: write_enable=1 for exactly this cycle, go WAIT.
REQ-025 WAIT: stay while write_busy=1; go IDLE the first cycle write_busy=0.
REQ-026 write_* outputs SHALL hold latched values from grant until the next grant.
REQ-027 Write arbitration SHALL be round-robin: single requester always wins; both requesting -> client not granted last wins; pointer updates only on grant.
REQ-028 Lookup accept SHALL occur only in write-FSM IDLE with write_busy=0; at most one lookup accepted per cycle; lookups SHALL NOT stall on outstanding responses.
REQ-029 Lookup arbitration SHALL be round-robin with its own pointer, rules as REQ-027.
REQ-030 Accepted lookup key SHALL appear on compare_data the next cycle; a client-tag/valid shift register of depth MATCH_LATENCY SHALL route match/match_addr to that client's rsp_* with rsp_valid high one cycle; response latency = MATCH_LATENCY+1 cycles after accept.
REQ-031 Write grant and lookup accept in the same IDLE cycle SHALL both occur; that lookup returns pre-write contents.
REQ-032 rsp_match/rsp_addr of the non-addressed client SHALL hold previous values; rsp_valid of both SHALL never be 1 in the same cycle.
REQ-033 compare_data SHALL hold its last value when no lookup is accepted.

Reset
REQ-034 While rst=0 at a clock edge: FSM -> IDLE; write_enable, write_delete, wr_ready*, lk_ready*, rsp_valid* = 0; write_addr, write_data, compare_data, rsp_match*, rsp_addr* = 0; tag pipeline cleared.
REQ-035 Both round-robin pointers SHALL reset to "client 1 granted last" so client 0 wins the first tie.
REQ-036 Reset mid-write or mid-lookup SHALL abort silently: no write_enable, no pending rsp_valid after release.

Verification
REQ-037 Both clients wr_valid, addr 0x005/0x1A0, data 0x123456/0xABCDEF, write_busy 2 cycles -> client 0 granted first, write_enable one cycle with 0x005/0x123456, client 1 issued only after write_busy=0.
REQ-038 Client 0 lookup 0x123456, CAM match=1 match_addr=0x005, MATCH_LATENCY=1 -> rsp_valid0=1, rsp_match0=1, rsp_addr0=0x005 exactly 2 cycles after lk_ready0; rsp_valid1 stays 0.
REQ-039 Both clients lookup continuously 6 cycles -> accepts alternate 0,1,0,1,0,1; responses return in accept order to matching client.
REQ-040 Lookup requested while FSM in WAIT with write_busy=1 -> lk_ready stays 0 until IDLE and write_busy=0.
REQ-041 rst=0 asserted the cycle after a write grant -> write_enable never pulses; all outputs 0 next cycle; client 0 wins first tie after release.
